// File: rtl/msrv32_dmem_ahb_slave.sv
// Word-organised data memory for the msrv32 load/store port, with byte-enable writes,
// registered read data and a configurable number of wait states per transfer.
module msrv32_dmem_ahb_slave #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_n_in,
  input  logic [31:0] ms_riscv32_mp_dmaddr_in,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  input  logic [3:0]  ms_riscv32_mp_dmwr_mask_in,
  input  logic        ms_riscv32_mp_dmwr_req_in,
  input  logic [1:0]  ahb_htrans_in,
  output logic        ahb_ready_out,
  output logic        ahb_resp_out,
  output logic [31:0] ms_riscv32_mp_dmdata_rd_out
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam bit         ZERO_WAIT = (WAIT_STATES == 0);
  localparam logic [3:0] WAIT_INIT = ZERO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  logic [1:0]            r_state;
  logic [1:0]            w_state_d;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_d;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [31:0]           r_data;
  logic [3:0]            r_mask;
  logic                  r_wr;
  logic                  r_err;
  logic [31:0]           r_rd;
  logic [31:0]           r_mem [2**ADDR_WIDTH];

  logic                  w_ready;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_in_idx;
  logic                  w_in_err;
  logic                  w_commit;
  logic [ADDR_WIDTH-1:0] w_c_idx;
  logic [31:0]           w_c_data;
  logic [3:0]            w_c_mask;
  logic                  w_c_wr;
  logic                  w_c_err;
  logic                  w_unused_addr;

  assign w_unused_addr = ^ms_riscv32_mp_dmaddr_in[1:0];

  assign w_ready  = (r_state != ST_WAIT);
  assign w_accept = w_ready & ahb_htrans_in[1];
  assign w_in_idx = ms_riscv32_mp_dmaddr_in[ADDR_WIDTH+1:2];
  assign w_in_err = |ms_riscv32_mp_dmaddr_in[31:ADDR_WIDTH+2];

  // Without wait states the transfer commits on its accept edge, straight from the inputs.
  assign w_commit = ((r_state == ST_WAIT) && (r_cnt == 4'd0)) || (ZERO_WAIT && w_accept);
  assign w_c_idx  = ZERO_WAIT ? w_in_idx                   : r_idx;
  assign w_c_data = ZERO_WAIT ? ms_riscv32_mp_dmdata_in    : r_data;
  assign w_c_mask = ZERO_WAIT ? ms_riscv32_mp_dmwr_mask_in : r_mask;
  assign w_c_wr   = ZERO_WAIT ? ms_riscv32_mp_dmwr_req_in  : r_wr;
  assign w_c_err  = ZERO_WAIT ? w_in_err                   : r_err;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    case (r_state)
      ST_IDLE, ST_ACCESS: begin
        if (w_accept) begin
          if (ZERO_WAIT) begin
            w_state_d = ST_ACCESS;
          end else begin
            w_state_d = ST_WAIT;
            w_cnt_d   = WAIT_INIT;
          end
        end else begin
          w_state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        w_cnt_d = r_cnt - 4'd1;
        if (r_cnt == 4'd0) begin
          w_state_d = ST_ACCESS;
          w_cnt_d   = 4'd0;
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_data  <= 32'd0;
      r_mask  <= 4'd0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
      r_rd    <= 32'd0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_accept) begin
        r_idx  <= w_in_idx;
        r_data <= ms_riscv32_mp_dmdata_in;
        r_mask <= ms_riscv32_mp_dmwr_mask_in;
        r_wr   <= ms_riscv32_mp_dmwr_req_in;
        r_err  <= w_in_err;
      end
      if (w_commit) begin
        if (w_c_err) begin
          r_rd <= 32'd0;
        end else if (!w_c_wr) begin
          r_rd <= r_mem[w_c_idx];
        end
      end
    end
  end

  // Array is never reset; a commit coinciding with reset is suppressed.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_n_in && w_commit && w_c_wr && !w_c_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_c_mask[i]) begin
          r_mem[w_c_idx][8*i +: 8] <= w_c_data[8*i +: 8];
        end
      end
    end
  end

  assign ahb_ready_out               = w_ready;
  assign ahb_resp_out                = (r_state == ST_ACCESS) & r_err;
  assign ms_riscv32_mp_dmdata_rd_out = r_rd;

endmodule

// File: tb/tb_msrv32_dmem_ahb_slave.sv
// Scoreboard bench: one-wait-state and zero-wait-state instances driven from shared stimulus.
module tb_msrv32_dmem_ahb_slave;

  logic        clk = 1'b0;
  logic        rst1_n;
  logic        rst0_n;
  logic [31:0] addr;
  logic [31:0] data;
  logic [3:0]  mask;
  logic        wr;
  logic [1:0]  htrans;

  logic        rdy1, resp1, rdy0, resp0;
  logic [31:0] rd1, rd0;

  logic        sel_z;
  logic        obs_rdy, obs_resp;
  logic [31:0] obs_rd;

  typedef struct packed {
    logic [31:0] rd;
    logic        resp;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] m1 [int];
  logic [31:0] m0 [int];
  logic [31:0] last1, last0;
  int          n_vec  = 0;
  int          n_miss = 0;

  always #5 clk = ~clk;

  assign obs_rdy  = sel_z ? rdy0  : rdy1;
  assign obs_resp = sel_z ? resp0 : resp1;
  assign obs_rd   = sel_z ? rd0   : rd1;

  msrv32_dmem_ahb_slave #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_dut1 (
    .ms_riscv32_mp_clk_in        (clk),
    .ms_riscv32_mp_rst_n_in      (rst1_n),
    .ms_riscv32_mp_dmaddr_in     (addr),
    .ms_riscv32_mp_dmdata_in     (data),
    .ms_riscv32_mp_dmwr_mask_in  (mask),
    .ms_riscv32_mp_dmwr_req_in   (wr),
    .ahb_htrans_in               (htrans),
    .ahb_ready_out               (rdy1),
    .ahb_resp_out                (resp1),
    .ms_riscv32_mp_dmdata_rd_out (rd1)
  );

  msrv32_dmem_ahb_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut0 (
    .ms_riscv32_mp_clk_in        (clk),
    .ms_riscv32_mp_rst_n_in      (rst0_n),
    .ms_riscv32_mp_dmaddr_in     (addr),
    .ms_riscv32_mp_dmdata_in     (data),
    .ms_riscv32_mp_dmwr_mask_in  (mask),
    .ms_riscv32_mp_dmwr_req_in   (wr),
    .ahb_htrans_in               (htrans),
    .ahb_ready_out               (rdy0),
    .ahb_resp_out                (resp0),
    .ms_riscv32_mp_dmdata_rd_out (rd0)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour: byte-lane writes, reads return the word, out-of-range gives 0/err.
  task automatic model_exp(input bit z, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] m, input logic w,
                           output logic [31:0] erd, output logic eresp);
    int          idx;
    logic [31:0] word;
    idx = int'(a[11:2]);
    if (a[31:12] != 20'd0) begin
      erd   = 32'd0;
      eresp = 1'b1;
    end else begin
      eresp = 1'b0;
      word  = z ? (m0.exists(idx) ? m0[idx] : 32'd0) : (m1.exists(idx) ? m1[idx] : 32'd0);
      if (w) begin
        for (int i = 0; i < 4; i++) if (m[i]) word[8*i +: 8] = d[8*i +: 8];
        if (z) m0[idx] = word; else m1[idx] = word;
        erd = z ? last0 : last1;
      end else begin
        erd = word;
      end
    end
    if (z) last0 = erd; else last1 = erd;
  endtask

  // Called on a negedge in the completion cycle.
  task automatic complete(input string tag);
    exp_t e;
    check_eq({tag, "_rdy_acc"}, {31'd0, obs_rdy}, 32'd1);
    check_eq({tag, "_sb_depth"}, exp_q.size(), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq({tag, "_rd"},   obs_rd, e.rd);
      check_eq({tag, "_resp"}, {31'd0, obs_resp}, {31'd0, e.resp});
    end
  endtask

  // Starts on a negedge with the slave ready; returns on the completion-cycle negedge,
  // so consecutive calls form back-to-back transfers.
  task automatic issue(input string tag, input bit z, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m, input logic w);
    exp_t e;
    check_eq({tag, "_rdy_pre"}, {31'd0, obs_rdy}, 32'd1);
    addr = a; data = d; mask = m; wr = w; htrans = 2'b10;
    model_exp(z, a, d, m, w, e.rd, e.resp);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (!z) begin
      // Junk during the wait cycle must be ignored.
      addr = $urandom; data = $urandom; mask = 4'hF; wr = 1'b1; htrans = 2'b11;
      @(negedge clk);
      check_eq({tag, "_rdy_wait"}, {31'd0, obs_rdy}, 32'd0);
      htrans = 2'b00;
      @(posedge clk);
    end else begin
      htrans = 2'b00;
    end
    @(negedge clk);
    complete(tag);
  endtask

  task automatic idle_cycles(input string tag, input logic [1:0] ht, input int n);
    for (int i = 0; i < n; i++) begin
      addr = 32'h0; data = 32'h0; mask = 4'hF; wr = 1'b1; htrans = ht;
      @(posedge clk);
      @(negedge clk);
      check_eq({tag, "_rdy"},  {31'd0, obs_rdy},  32'd1);
      check_eq({tag, "_resp"}, {31'd0, obs_resp}, 32'd0);
      check_eq({tag, "_rd"},   obs_rd, sel_z ? last0 : last1);
    end
    htrans = 2'b00;
  endtask

  initial begin
    rst1_n = 1'b0; rst0_n = 1'b0; sel_z = 1'b0;
    addr = 0; data = 0; mask = 0; wr = 0; htrans = 2'b00;
    last1 = 32'd0; last0 = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst1_n = 1'b1;
    @(negedge clk);
    check_eq("rst_rdy",  {31'd0, rdy1},  32'd1);
    check_eq("rst_resp", {31'd0, resp1}, 32'd0);
    check_eq("rst_rd",   rd1, 32'd0);

    issue("pre_wr", 1'b0, 32'h4, 32'h11223344, 4'hF, 1'b1);
    idle_cycles("gap0", 2'b00, 1);

    // Reset during the wait cycle drops the write.
    addr = 32'h4; data = 32'hDEADBEEF; mask = 4'hF; wr = 1'b1; htrans = 2'b10;
    @(posedge clk);
    #1;
    htrans = 2'b00;
    rst1_n = 1'b0;
    #1;
    check_eq("midrst_rdy",  {31'd0, rdy1},  32'd1);
    check_eq("midrst_resp", {31'd0, resp1}, 32'd0);
    check_eq("midrst_rd",   rd1, 32'd0);
    @(negedge clk);
    rst1_n = 1'b1;
    last1 = 32'd0;
    @(negedge clk);
    issue("post_rst_rd", 1'b0, 32'h4, 32'h0, 4'h0, 1'b0);

    issue("word_wr", 1'b0, 32'h4, 32'hFFFFFFFF, 4'hF, 1'b1);
    issue("word_rd", 1'b0, 32'h4, 32'h0, 4'h0, 1'b0);

    issue("lane_clr", 1'b0, 32'h0, 32'h00000000, 4'hF, 1'b1);
    issue("lane_b1",  1'b0, 32'h1, 32'h0000FF00, 4'b0010, 1'b1);
    issue("lane_rd1", 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    issue("lane_h1",  1'b0, 32'h2, 32'hFFFF0000, 4'b1100, 1'b1);
    issue("lane_rd2", 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    issue("mask0_wr", 1'b0, 32'h0, 32'h12121212, 4'h0, 1'b1);
    issue("mask0_rd", 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    idle_cycles("gap1", 2'b00, 2);

    issue("b2b_wr", 1'b0, 32'h8, 32'hAAAAAAAA, 4'hF, 1'b1);
    issue("b2b_rd", 1'b0, 32'h8, 32'h0, 4'h0, 1'b0);

    issue("err_wr",  1'b0, 32'h00001000, 32'h12345678, 4'hF, 1'b1);
    issue("err_chk", 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    issue("err_rd",  1'b0, 32'h80000000, 32'h0, 4'h0, 1'b0);
    issue("seq_rd",  1'b0, 32'h8, 32'h0, 4'h0, 1'b0);
    idle_cycles("ign_idle", 2'b00, 3);
    idle_cycles("ign_busy", 2'b01, 3);
    issue("ign_chk", 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    idle_cycles("gap2", 2'b00, 1);

    // Zero-wait instance.
    rst1_n = 1'b0; rst0_n = 1'b1; sel_z = 1'b1;
    @(negedge clk);
    check_eq("z_rst_rdy",  {31'd0, rdy0},  32'd1);
    check_eq("z_rst_resp", {31'd0, resp0}, 32'd0);
    check_eq("z_rst_rd",   rd0, 32'd0);
    for (int i = 0; i < 8; i++) begin
      issue("z_wr", 1'b1, 32'h10, $urandom, 4'hF, 1'b1);
      issue("z_rd", 1'b1, 32'h10, 32'h0, 4'h0, 1'b0);
    end
    issue("z_err", 1'b1, 32'h00002010, 32'h5555AAAA, 4'hF, 1'b1);
    issue("z_chk", 1'b1, 32'h10, 32'h0, 4'h0, 1'b0);
    idle_cycles("z_idle", 2'b00, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
